// File: rtl/bus_slave_mem.sv
// Word-addressed SRAM bus slave with independent write/read channels.
// Each channel runs an IDLE/WAIT/RDY handshake FSM with programmable wait states and a last-beat done pulse.
module bus_slave_mem #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 14,
    parameter int unsigned SW      = 4,
    parameter int unsigned SLV_ID  = 0,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned WR_WAIT = 0,
    parameter int unsigned RD_WAIT = 0
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iSlvWrReq,
    input  logic          iSlvWrValid,
    input  logic [AW-1:0] iSlvWrAddr,
    input  logic [SW-1:0] iSlvWrSel,
    input  logic          iSlvWrLast,
    input  logic [DW-1:0] iSlvWrData,
    output logic          oSlvWrReady,
    input  logic          iSlvRdReq,
    input  logic          iSlvRdValid,
    input  logic [AW-1:0] iSlvRdAddr,
    input  logic [SW-1:0] iSlvRdSel,
    input  logic          iSlvRdLast,
    output logic          oSlvRdReady,
    output logic [DW-1:0] oSlvRdData,
    output logic          oWrDone,
    output logic          oRdDone
);
    localparam int unsigned IW   = AW - 2;
    localparam int unsigned MW   = $clog2(DEPTH);
    localparam bit          FULL = (DEPTH >= (2 ** IW));
    localparam logic [3:0]  WR_WAIT_C = 4'(WR_WAIT);
    localparam logic [3:0]  RD_WAIT_C = 4'(RD_WAIT);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RDY = 2'd2} state_t;

    logic [DW-1:0] mem [DEPTH];

    logic          hit_w_c, hit_r_c, wr_acc_c, rd_acc_c;
    logic          wr_in_range_c, rd_in_range_c;
    logic [IW-1:0] wr_idx_c, rd_idx_c;
    logic          unused_addr_bits;

    state_t        wr_state, wr_state_nxt, rd_state, rd_state_nxt;
    logic [3:0]    wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt;
    logic          wr_rdy_nxt, wr_done_nxt, rd_rdy_nxt, rd_done_nxt;

    assign hit_w_c  = iSlvWrReq & iSlvWrValid & (iSlvWrSel == SW'(SLV_ID));
    assign hit_r_c  = iSlvRdReq & iSlvRdValid & (iSlvRdSel == SW'(SLV_ID));
    assign wr_acc_c = (wr_state == S_RDY) & hit_w_c;
    assign rd_acc_c = (rd_state == S_RDY) & hit_r_c;
    assign wr_idx_c = iSlvWrAddr[AW-1:2];
    assign rd_idx_c = iSlvRdAddr[AW-1:2];
    assign unused_addr_bits = ^{iSlvWrAddr[1:0], iSlvRdAddr[1:0]};

    // Out-of-range beats are still acknowledged; only the memory access is suppressed.
    if (FULL) begin : g_full
        assign wr_in_range_c = 1'b1;
        assign rd_in_range_c = 1'b1;
    end else begin : g_part
        assign wr_in_range_c = (wr_idx_c < IW'(DEPTH));
        assign rd_in_range_c = (rd_idx_c < IW'(DEPTH));
    end

    // Write channel: state register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_state    <= S_IDLE;
            wr_cnt      <= '0;
            oSlvWrReady <= 1'b0;
            oWrDone     <= 1'b0;
        end else begin
            wr_state    <= wr_state_nxt;
            wr_cnt      <= wr_cnt_nxt;
            oSlvWrReady <= wr_rdy_nxt;
            oWrDone     <= wr_done_nxt;
        end
    end

    // Write channel: next state
    always_comb begin
        wr_state_nxt = wr_state;
        wr_cnt_nxt   = wr_cnt;
        case (wr_state)
            S_IDLE: if (hit_w_c) begin
                if (WR_WAIT_C != 4'd0) begin
                    wr_state_nxt = S_WAIT;
                    wr_cnt_nxt   = WR_WAIT_C;
                end else begin
                    wr_state_nxt = S_RDY;
                end
            end
            S_WAIT: begin
                if (!hit_w_c) begin
                    wr_state_nxt = S_IDLE;
                    wr_cnt_nxt   = '0;
                end else if (wr_cnt == 4'd1) begin
                    wr_state_nxt = S_RDY;
                    wr_cnt_nxt   = '0;
                end else begin
                    wr_cnt_nxt   = wr_cnt - 4'd1;
                end
            end
            S_RDY:   wr_state_nxt = S_IDLE;
            default: wr_state_nxt = S_IDLE;
        endcase
    end

    // Write channel: next-cycle output values
    always_comb begin
        wr_rdy_nxt  = (wr_state_nxt == S_RDY);
        wr_done_nxt = wr_acc_c & iSlvWrLast;
    end

    // Read channel: state register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rd_state    <= S_IDLE;
            rd_cnt      <= '0;
            oSlvRdReady <= 1'b0;
            oRdDone     <= 1'b0;
        end else begin
            rd_state    <= rd_state_nxt;
            rd_cnt      <= rd_cnt_nxt;
            oSlvRdReady <= rd_rdy_nxt;
            oRdDone     <= rd_done_nxt;
        end
    end

    // Read channel: next state
    always_comb begin
        rd_state_nxt = rd_state;
        rd_cnt_nxt   = rd_cnt;
        case (rd_state)
            S_IDLE: if (hit_r_c) begin
                if (RD_WAIT_C != 4'd0) begin
                    rd_state_nxt = S_WAIT;
                    rd_cnt_nxt   = RD_WAIT_C;
                end else begin
                    rd_state_nxt = S_RDY;
                end
            end
            S_WAIT: begin
                if (!hit_r_c) begin
                    rd_state_nxt = S_IDLE;
                    rd_cnt_nxt   = '0;
                end else if (rd_cnt == 4'd1) begin
                    rd_state_nxt = S_RDY;
                    rd_cnt_nxt   = '0;
                end else begin
                    rd_cnt_nxt   = rd_cnt - 4'd1;
                end
            end
            S_RDY:   rd_state_nxt = S_IDLE;
            default: rd_state_nxt = S_IDLE;
        endcase
    end

    // Read channel: next-cycle output values
    always_comb begin
        rd_rdy_nxt  = (rd_state_nxt == S_RDY);
        rd_done_nxt = rd_acc_c & iSlvRdLast;
    end

    // Read data register; non-blocking update gives read-before-write on a shared index
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oSlvRdData <= '0;
        end else if (rd_acc_c) begin
            oSlvRdData <= rd_in_range_c ? mem[rd_idx_c[MW-1:0]] : '0;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge iClk) begin
        if (wr_acc_c && wr_in_range_c) begin
            mem[wr_idx_c[MW-1:0]] <= iSlvWrData;
        end
    end

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: a zero-wait instance and a waited, shallow instance share one stimulus.
module tb_bus_slave_mem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req, wr_valid, wr_last, rd_req, rd_valid, rd_last;
    logic [11:0] wr_addr, rd_addr;
    logic [3:0]  wr_sel, rd_sel;
    logic [13:0] wr_data;

    logic        wr_rdy0, rd_rdy0, wr_done0, rd_done0;
    logic        wr_rdy1, rd_rdy1, wr_done1, rd_done1;
    logic [13:0] rd_data0, rd_data1;

    int n_tests;
    int n_fail;
    int n;
    logic [13:0] burst [4] = '{14'h0123, 14'h0456, 14'h0789, 14'h3FFF};

    always #5 clk = ~clk;

    bus_slave_mem u_dut0 (
        .iClk(clk), .iRst_n(rst_n),
        .iSlvWrReq(wr_req), .iSlvWrValid(wr_valid), .iSlvWrAddr(wr_addr), .iSlvWrSel(wr_sel),
        .iSlvWrLast(wr_last), .iSlvWrData(wr_data), .oSlvWrReady(wr_rdy0),
        .iSlvRdReq(rd_req), .iSlvRdValid(rd_valid), .iSlvRdAddr(rd_addr), .iSlvRdSel(rd_sel),
        .iSlvRdLast(rd_last), .oSlvRdReady(rd_rdy0), .oSlvRdData(rd_data0),
        .oWrDone(wr_done0), .oRdDone(rd_done0)
    );

    bus_slave_mem #(.DEPTH(256), .WR_WAIT(3), .RD_WAIT(2)) u_dut1 (
        .iClk(clk), .iRst_n(rst_n),
        .iSlvWrReq(wr_req), .iSlvWrValid(wr_valid), .iSlvWrAddr(wr_addr), .iSlvWrSel(wr_sel),
        .iSlvWrLast(wr_last), .iSlvWrData(wr_data), .oSlvWrReady(wr_rdy1),
        .iSlvRdReq(rd_req), .iSlvRdValid(rd_valid), .iSlvRdAddr(rd_addr), .iSlvRdSel(rd_sel),
        .iSlvRdLast(rd_last), .oSlvRdReady(rd_rdy1), .oSlvRdData(rd_data1),
        .oWrDone(wr_done1), .oRdDone(rd_done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_drive(input logic [11:0] a, input logic [13:0] d, input logic l, input logic [3:0] s);
        wr_req = 1'b1; wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_last = l; wr_sel = s;
    endtask

    task automatic rd_drive(input logic [11:0] a, input logic l, input logic [3:0] s);
        rd_req = 1'b1; rd_valid = 1'b1; rd_addr = a; rd_last = l; rd_sel = s;
    endtask

    task automatic wr_idle();
        wr_req = 1'b0; wr_valid = 1'b0; wr_addr = 'x; wr_data = 'x; wr_last = 1'bx; wr_sel = '0;
    endtask

    task automatic rd_idle();
        rd_req = 1'b0; rd_valid = 1'b0; rd_addr = 'x; rd_last = 1'bx; rd_sel = '0;
    endtask

    // One zero-wait write beat on u_dut0; request stays asserted afterwards
    task automatic write0(input logic [11:0] a, input logic [13:0] d, input logic l);
        wr_drive(a, d, l, 4'd0);
        tick();
        chk("wr_rdy_up", 32'(wr_rdy0), 32'd1);
        tick();
        chk("wr_rdy_down", 32'(wr_rdy0), 32'd0);
        chk("wr_done", 32'(wr_done0), 32'(l));
    endtask

    task automatic read0(input logic [11:0] a, input logic l, input logic [13:0] exp);
        rd_drive(a, l, 4'd0);
        tick();
        chk("rd_rdy_up", 32'(rd_rdy0), 32'd1);
        tick();
        chk("rd_rdy_down", 32'(rd_rdy0), 32'd0);
        chk("rd_data", 32'(rd_data0), 32'(exp));
        chk("rd_done", 32'(rd_done0), 32'(l));
    endtask

    task automatic count_wr1(output int cnt);
        cnt = 0;
        do begin tick(); cnt++; end while (!wr_rdy1 && cnt < 20);
    endtask

    task automatic count_rd1(output int cnt);
        cnt = 0;
        do begin tick(); cnt++; end while (!rd_rdy1 && cnt < 20);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        wr_idle();
        rd_idle();
        tick();
        tick();
        chk("rst_wr_rdy0", 32'(wr_rdy0), 32'd0);
        chk("rst_rd_rdy0", 32'(rd_rdy0), 32'd0);
        chk("rst_rd_data0", 32'(rd_data0), 32'd0);
        chk("rst_wr_done0", 32'(wr_done0), 32'd0);
        chk("rst_rd_done0", 32'(rd_done0), 32'd0);
        chk("rst_wr_rdy1", 32'(wr_rdy1), 32'd0);
        chk("rst_rd_data1", 32'(rd_data1), 32'd0);
        rst_n = 1'b1;
        tick();

        // single write then read
        write0(12'h010, 14'h1ABC, 1'b1);
        wr_idle();
        tick();
        chk("t1_wr_done_pulse", 32'(wr_done0), 32'd0);
        read0(12'h010, 1'b1, 14'h1ABC);
        rd_idle();
        tick();
        chk("t1_rd_done_pulse", 32'(rd_done0), 32'd0);

        // 4-beat bursts at peak rate
        for (int i = 0; i < 4; i++) write0(12'h100 + 12'(4 * i), burst[i], (i == 3));
        wr_idle();
        tick();
        chk("t2_wr_done_pulse", 32'(wr_done0), 32'd0);
        for (int i = 0; i < 4; i++) read0(12'h100 + 12'(4 * i), (i == 3), burst[i]);
        rd_idle();
        tick();
        chk("t2_rd_done_pulse", 32'(rd_done0), 32'd0);
        tick();

        // wait-state latency on u_dut1
        wr_drive(12'h200, 14'h0AAA, 1'b1, 4'd0);
        count_wr1(n);
        chk("t3_wr_latency", 32'(n), 32'd4);
        tick();
        chk("t3_wr_rdy_down", 32'(wr_rdy1), 32'd0);
        chk("t3_wr_done", 32'(wr_done1), 32'd1);
        wr_idle();
        tick();
        tick();
        rd_drive(12'h200, 1'b1, 4'd0);
        count_rd1(n);
        chk("t3_rd_latency", 32'(n), 32'd3);
        tick();
        chk("t3_rd_data", 32'(rd_data1), 32'h0AAA);
        chk("t3_rd_done", 32'(rd_done1), 32'd1);
        rd_idle();
        tick();

        // index beyond DEPTH on u_dut1: acknowledged, write dropped, read returns 0
        wr_drive(12'h400, 14'h1555, 1'b1, 4'd0);
        count_wr1(n);
        chk("oor_wr_latency", 32'(n), 32'd4);
        tick();
        wr_idle();
        tick();
        rd_drive(12'h400, 1'b1, 4'd0);
        count_rd1(n);
        chk("oor_rd_latency", 32'(n), 32'd3);
        tick();
        chk("oor_rd_data", 32'(rd_data1), 32'd0);
        rd_idle();
        tick();
        tick();

        // select mismatch on both channels
        write0(12'h020, 14'h0777, 1'b1);
        wr_idle();
        tick();
        read0(12'h020, 1'b1, 14'h0777);
        rd_idle();
        tick();
        wr_drive(12'h020, 14'h0055, 1'b1, 4'd1);
        rd_drive(12'h020, 1'b1, 4'd1);
        n = 0;
        repeat (20) begin
            tick();
            if (wr_rdy0 | wr_rdy1 | rd_rdy0 | rd_rdy1) n++;
        end
        chk("t4_no_ready", 32'(n), 32'd0);
        chk("t4_rd_data_held", 32'(rd_data0), 32'h0777);
        wr_idle();
        rd_idle();
        tick();
        read0(12'h020, 1'b1, 14'h0777);
        rd_idle();
        tick();

        // same-edge write and read of one word
        write0(12'h040, 14'h1111, 1'b1);
        wr_idle();
        tick();
        wr_drive(12'h040, 14'h2AAA, 1'b1, 4'd0);
        rd_drive(12'h040, 1'b1, 4'd0);
        tick();
        chk("t5_wr_rdy", 32'(wr_rdy0), 32'd1);
        chk("t5_rd_rdy", 32'(rd_rdy0), 32'd1);
        tick();
        chk("t5_rd_old", 32'(rd_data0), 32'h1111);
        wr_idle();
        rd_idle();
        tick();
        read0(12'h040, 1'b1, 14'h2AAA);
        rd_idle();
        tick();
        tick();

        // reset during a waited write on u_dut1
        wr_drive(12'h080, 14'h0321, 1'b1, 4'd0);
        count_wr1(n);
        chk("t6_pre_latency", 32'(n), 32'd4);
        tick();
        wr_idle();
        tick();
        wr_drive(12'h080, 14'h3ABC, 1'b1, 4'd0);
        tick();
        tick();
        chk("t6_in_wait", 32'(wr_rdy1), 32'd0);
        chk("t6_dut0_done_before", 32'(wr_done0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_done_drop", 32'(wr_done0), 32'd0);
        chk("t6_async_rd_data", 32'(rd_data1), 32'd0);
        wr_idle();
        tick();
        chk("t6_rdy_in_reset", 32'(wr_rdy1), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_rdy_after", 32'(wr_rdy1), 32'd0);
        rd_drive(12'h080, 1'b1, 4'd0);
        count_rd1(n);
        chk("t6_rd_latency", 32'(n), 32'd3);
        tick();
        chk("t6_word_unchanged", 32'(rd_data1), 32'h0321);
        rd_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
